// File: rtl/viterbi_ber_checker.sv
// viterbi_ber_checker
// Bit-error-rate checker placed after the convolutional encoder / channel /
// Viterbi decoder chain. Reference bits are queued in a FIFO as they enter
// the encoder and are popped, in order, against each decoded bit. Decoder
// latency up to DEPTH bits is absorbed by the FIFO.
// Optional feature macro: BER_BURST_STATS_EN (longest mismatch run tracking).
module viterbi_ber_checker #(
    parameter int DEPTH  = 64,
    parameter int WINDOW = 256,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          ref_valid_i,
    input  logic          ref_bit_i,
    input  logic          dec_valid_i,
    input  logic          dec_bit_i,
    output logic          busy_o,
    output logic          err_o,
    output logic [CW-1:0] bit_ct_o,
    output logic [CW-1:0] err_ct_o,
    output logic [CW-1:0] win_err_o,
    output logic          win_done_o,
    output logic          overflow_o,
    output logic          underflow_o,
    output logic [CW-1:0] max_burst_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WCW = $clog2(WINDOW);

    localparam logic [CW-1:0]  CT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0]  CT_ONE   = CW'(1);
    localparam logic [AW:0]    PTR_ONE  = (AW+1)'(1);
    localparam logic [WCW-1:0] WIN_ONE  = WCW'(1);
    localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t         state;
    logic [DEPTH-1:0] mem;
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [WCW-1:0] win_cnt;
    logic [CW-1:0]  win_acc;

    logic          active;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push_req;
    logic          pop_req;
    logic          uflow_evt;
    logic          oflow_evt;
    logic          do_push;
    logic          do_pop;
    logic          mismatch;
    logic [CW-1:0] win_acc_nxt;
    logic [CW-1:0] bit_ct_nxt;
    logic [CW-1:0] err_ct_nxt;

    // Strobes only matter in RUN, and a start pulse overrides them
    assign active     = (state == RUN) && !start_i;
    // The extra pointer MSB separates full from empty when the indices match
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req   = active && ref_valid_i;
    assign pop_req    = active && dec_valid_i;
    // A pop on an empty FIFO is an underflow even if a push arrives with it
    assign uflow_evt  = pop_req && fifo_empty;
    // A full FIFO can still take a push when a pop frees a slot the same cycle
    assign oflow_evt  = push_req && fifo_full && !pop_req;
    assign do_pop     = pop_req && !fifo_empty;
    assign do_push    = push_req && !uflow_evt && !oflow_evt;
    assign mismatch   = do_pop && (mem[rd_ptr[AW-1:0]] != dec_bit_i);

    assign win_acc_nxt = (mismatch && (win_acc != CT_MAX)) ? win_acc + CT_ONE : win_acc;
    assign bit_ct_nxt  = (bit_ct_o != CT_MAX) ? bit_ct_o + CT_ONE : bit_ct_o;
    assign err_ct_nxt  = (mismatch && (err_ct_o != CT_MAX)) ? err_ct_o + CT_ONE : err_ct_o;

    // Reference bit storage, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= ref_bit_i;
        end
    end

    // Control FSM with FIFO pointers, counters, window and fault flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
            win_done_o  <= 1'b0;
            bit_ct_o    <= '0;
            err_ct_o    <= '0;
            win_err_o   <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            win_cnt     <= '0;
            win_acc     <= '0;
        end else begin
            err_o      <= 1'b0;
            win_done_o <= 1'b0;
            if (start_i) begin
                state       <= RUN;
                busy_o      <= 1'b1;
                bit_ct_o    <= '0;
                err_ct_o    <= '0;
                win_err_o   <= '0;
                overflow_o  <= 1'b0;
                underflow_o <= 1'b0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                win_cnt     <= '0;
                win_acc     <= '0;
            end else if (state == RUN) begin
                if (oflow_evt) begin
                    overflow_o <= 1'b1;
                    state      <= HALT;
                    busy_o     <= 1'b0;
                end
                if (uflow_evt) begin
                    underflow_o <= 1'b1;
                    state       <= HALT;
                    busy_o      <= 1'b0;
                end
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (do_pop) begin
                    rd_ptr   <= rd_ptr + PTR_ONE;
                    err_o    <= mismatch;
                    bit_ct_o <= bit_ct_nxt;
                    err_ct_o <= err_ct_nxt;
                    if (win_cnt == WIN_LAST) begin
                        win_err_o  <= win_acc_nxt;
                        win_done_o <= 1'b1;
                        win_cnt    <= '0;
                        win_acc    <= '0;
                    end else begin
                        win_cnt <= win_cnt + WIN_ONE;
                        win_acc <= win_acc_nxt;
                    end
                end
            end
        end
    end

`ifdef BER_BURST_STATS_EN
    logic [CW-1:0] run_len;
    logic [CW-1:0] run_nxt;

    assign run_nxt = (run_len != CT_MAX) ? run_len + CT_ONE : run_len;

    // Current mismatch run and the longest run seen since start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_len     <= '0;
            max_burst_o <= '0;
        end else if (start_i) begin
            run_len     <= '0;
            max_burst_o <= '0;
        end else if (do_pop) begin
            if (mismatch) begin
                run_len <= run_nxt;
                if (run_nxt > max_burst_o) begin
                    max_burst_o <= run_nxt;
                end
            end else begin
                run_len <= '0;
            end
        end
    end
`else
    assign max_burst_o = '0;
`endif

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb_viterbi_ber_checker
// Directed table-driven bench for viterbi_ber_checker (default parameters)
// plus streamed sequences for windowing, overflow, burst and reset cases.
module tb_viterbi_ber_checker;

    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic          ref_valid_i;
    logic          ref_bit_i;
    logic          dec_valid_i;
    logic          dec_bit_i;
    logic          busy_o;
    logic          err_o;
    logic [CW-1:0] bit_ct_o;
    logic [CW-1:0] err_ct_o;
    logic [CW-1:0] win_err_o;
    logic          win_done_o;
    logic          overflow_o;
    logic          underflow_o;
    logic [CW-1:0] max_burst_o;

    viterbi_ber_checker #(
        .DEPTH (64),
        .WINDOW(256),
        .CW    (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .ref_valid_i(ref_valid_i),
        .ref_bit_i  (ref_bit_i),
        .dec_valid_i(dec_valid_i),
        .dec_bit_i  (dec_bit_i),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .bit_ct_o   (bit_ct_o),
        .err_ct_o   (err_ct_o),
        .win_err_o  (win_err_o),
        .win_done_o (win_done_o),
        .overflow_o (overflow_o),
        .underflow_o(underflow_o),
        .max_burst_o(max_burst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic st;
        logic rv;
        logic rb;
        logic dv;
        logic db;
        logic busy;
        logic err;
        int   bit_ct;
        int   err_ct;
        logic ovf;
        logic unf;
    } vec_t;

    vec_t tbl[13];
    logic prbs[0:299];

    int n_cmp;
    int n_fail;
    int err_pulses;
    int win_pulses;
    int first_win;
    int exp_burst;

    function automatic vec_t mk(input logic st, input logic rv, input logic rb,
                                input logic dv, input logic db, input logic busy,
                                input logic err, input int bit_ct, input int err_ct,
                                input logic ovf, input logic unf);
        vec_t v;
        v.st = st; v.rv = rv; v.rb = rb; v.dv = dv; v.db = db;
        v.busy = busy; v.err = err; v.bit_ct = bit_ct; v.err_ct = err_ct;
        v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    function automatic logic inv(input int mode, input int i);
        if (mode == 1) return (i < 256) && (i % 16 == 15);
        if (mode == 2) return ((i >= 5) && (i <= 20)) || ((i >= 25) && (i <= 27));
        return 1'b0;
    endfunction

    // Compare one value and log any difference
    task automatic checkOutput(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then settle 1 ns after the rising edge
    task automatic applyStimulus(input logic st, input logic rv, input logic rb,
                                 input logic dv, input logic db);
        start_i     = st;
        ref_valid_i = rv;
        ref_bit_i   = rb;
        dec_valid_i = dv;
        dec_bit_i   = db;
        @(posedge clk);
        #1;
        if (err_o === 1'b1) err_pulses++;
        if (win_done_o === 1'b1) begin
            win_pulses++;
            if (win_pulses == 1) first_win = int'(win_err_o);
        end
    endtask

    // Stream n PRBS bits, decoded copy delayed dly cycles, run ncyc cycles
    task automatic runStream(input int n, input int dly, input int mode, input int ncyc);
        logic rv, rb, dv, db;
        err_pulses = 0;
        win_pulses = 0;
        first_win  = -1;
        for (int c = 0; c < ncyc; c++) begin
            rv = 1'b0; rb = 1'b0; dv = 1'b0; db = 1'b0;
            if (c < n) begin
                rv = 1'b1;
                rb = prbs[c];
            end
            if ((c >= dly) && (c - dly < n)) begin
                dv = 1'b1;
                db = prbs[c - dly] ^ inv(mode, c - dly);
            end
            applyStimulus(1'b0, rv, rb, dv, db);
        end
    endtask

    initial begin
        logic [6:0] lfsr;
        n_cmp = 0;
        n_fail = 0;
        err_pulses = 0;
        win_pulses = 0;
        first_win = -1;
`ifdef BER_BURST_STATS_EN
        exp_burst = 16;
`else
        exp_burst = 0;
`endif
        lfsr = 7'h5A;
        for (int i = 0; i < 300; i++) begin
            prbs[i] = lfsr[0];
            lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end

        //                st  rv  rb  dv  db  busy err bit ect ovf unf
        tbl[0]  = mk(1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0, 0, 0, 1'b0,1'b0);
        tbl[1]  = mk(1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0, 0, 0, 1'b0,1'b0);
        tbl[2]  = mk(1'b0,1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0, 0, 0, 1'b0,1'b0);
        tbl[3]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0, 0, 0, 1'b0,1'b0);
        tbl[4]  = mk(1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0, 1, 0, 1'b0,1'b0);
        tbl[5]  = mk(1'b0,1'b0,1'b0,1'b1,1'b1, 1'b1,1'b1, 2, 1, 1'b0,1'b0);
        tbl[6]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1, 3, 2, 1'b0,1'b0);
        tbl[7]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0, 3, 2, 1'b0,1'b0);
        tbl[8]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0, 3, 2, 1'b0,1'b1);
        tbl[9]  = mk(1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0, 3, 2, 1'b0,1'b1);
        tbl[10] = mk(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0, 0, 0, 1'b0,1'b0);
        tbl[11] = mk(1'b0,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0, 0, 0, 1'b0,1'b1);
        tbl[12] = mk(1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0, 0, 0, 1'b0,1'b0);

        rst = 1'b0;
        start_i = 1'b0; ref_valid_i = 1'b0; ref_bit_i = 1'b0;
        dec_valid_i = 1'b0; dec_bit_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.busy", int'(busy_o), 0);
        checkOutput("rst.err", int'(err_o), 0);
        checkOutput("rst.bit_ct", int'(bit_ct_o), 0);
        checkOutput("rst.err_ct", int'(err_ct_o), 0);
        checkOutput("rst.win_err", int'(win_err_o), 0);
        checkOutput("rst.win_done", int'(win_done_o), 0);
        checkOutput("rst.ovf", int'(overflow_o), 0);
        checkOutput("rst.unf", int'(underflow_o), 0);
        checkOutput("rst.max_burst", int'(max_burst_o), 0);
        rst = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].st, tbl[i].rv, tbl[i].rb, tbl[i].dv, tbl[i].db);
            checkOutput($sformatf("tbl%0d.busy", i), int'(busy_o), int'(tbl[i].busy));
            checkOutput($sformatf("tbl%0d.err", i), int'(err_o), int'(tbl[i].err));
            checkOutput($sformatf("tbl%0d.bit_ct", i), int'(bit_ct_o), tbl[i].bit_ct);
            checkOutput($sformatf("tbl%0d.err_ct", i), int'(err_ct_o), tbl[i].err_ct);
            checkOutput($sformatf("tbl%0d.ovf", i), int'(overflow_o), int'(tbl[i].ovf));
            checkOutput($sformatf("tbl%0d.unf", i), int'(underflow_o), int'(tbl[i].unf));
        end

        $display("[TB] clean 300-bit stream, delay 20");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runStream(300, 20, 0, 322);
        checkOutput("clean.bit_ct", int'(bit_ct_o), 300);
        checkOutput("clean.err_ct", int'(err_ct_o), 0);
        checkOutput("clean.err_pulses", err_pulses, 0);
        checkOutput("clean.win_pulses", win_pulses, 1);
        checkOutput("clean.win_err", first_win, 0);
        checkOutput("clean.busy", int'(busy_o), 1);
        checkOutput("clean.ovf", int'(overflow_o), 0);
        checkOutput("clean.unf", int'(underflow_o), 0);

        $display("[TB] 300-bit stream with 16 spaced errors");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runStream(300, 20, 1, 322);
        checkOutput("spaced.bit_ct", int'(bit_ct_o), 300);
        checkOutput("spaced.err_ct", int'(err_ct_o), 16);
        checkOutput("spaced.err_pulses", err_pulses, 16);
        checkOutput("spaced.win_pulses", win_pulses, 1);
        checkOutput("spaced.win_err", first_win, 16);

        $display("[TB] burst of 16 then burst of 3");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runStream(40, 2, 2, 44);
        checkOutput("burst.bit_ct", int'(bit_ct_o), 40);
        checkOutput("burst.err_ct", int'(err_ct_o), 19);
        checkOutput("burst.err_pulses", err_pulses, 19);
        checkOutput("burst.max_burst", int'(max_burst_o), exp_burst);

        $display("[TB] overflow");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 1'b1, i[0], 1'b0, 1'b0);
        end
        checkOutput("full.ovf", int'(overflow_o), 0);
        checkOutput("full.busy", int'(busy_o), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("fullpp.bit_ct", int'(bit_ct_o), 1);
        checkOutput("fullpp.err", int'(err_o), 0);
        checkOutput("fullpp.ovf", int'(overflow_o), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf.ovf", int'(overflow_o), 1);
        checkOutput("ovf.busy", int'(busy_o), 0);
        checkOutput("ovf.unf", int'(underflow_o), 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("halt.bit_ct", int'(bit_ct_o), 1);
        checkOutput("halt.err_ct", int'(err_ct_o), 0);
        checkOutput("halt.ovf", int'(overflow_o), 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rerun.busy", int'(busy_o), 1);
        checkOutput("rerun.ovf", int'(overflow_o), 0);
        checkOutput("rerun.bit_ct", int'(bit_ct_o), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("rerun.bit_ct1", int'(bit_ct_o), 1);
        checkOutput("rerun.err", int'(err_o), 0);

        $display("[TB] async reset mid-stream");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        runStream(150, 5, 2, 105);
        checkOutput("prerst.bit_ct", int'(bit_ct_o), 100);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst.busy", int'(busy_o), 0);
        checkOutput("midrst.bit_ct", int'(bit_ct_o), 0);
        checkOutput("midrst.err_ct", int'(err_ct_o), 0);
        checkOutput("midrst.win_err", int'(win_err_o), 0);
        checkOutput("midrst.max_burst", int'(max_burst_o), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("postrst.busy", int'(busy_o), 0);
        checkOutput("postrst.bit_ct", int'(bit_ct_o), 0);
        checkOutput("postrst.unf", int'(underflow_o), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("postrst.err", int'(err_o), 1);
        checkOutput("postrst.err_ct", int'(err_ct_o), 1);
        checkOutput("postrst.busy1", int'(busy_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
